// File: rtl/pixel_divider_if.sv
// Start/done handshake bundle for the sequential pixel divider.
// The requester drives start/a/b; the divider returns its status and results.
interface pixel_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             div_by_zero;

    modport master (output start, a, b, input busy, done, q, r, div_by_zero);
    modport slave  (input start, a, b, output busy, done, q, r, div_by_zero);
endinterface

// File: rtl/pixel_divider.sv
// Restoring shift-subtract unsigned divider, one quotient bit per clock.
// Recovers unscaled pixels on watermark extraction: q = a / b, r = a % b.
module pixel_divider #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    pixel_divider_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd, dvs, rem, quo;
    logic [WIDTH-1:0] q_q, r_q;
    logic             dbz_q;

    // The partial remainder can have its MSB set when b > 2^(WIDTH-1),
    // so the shifted value needs one extra bit before the compare.
    logic [WIDTH:0]   rem_t;
    logic [WIDTH-1:0] diff, rem_nxt;
    logic             ge;

    assign rem_t   = {rem, dvd[WIDTH-1]};
    assign ge      = rem_t >= {1'b0, dvs};
    assign diff    = rem_t[WIDTH-1:0] - dvs;
    assign rem_nxt = ge ? diff : rem_t[WIDTH-1:0];

    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.q           = q_q;
    assign bus.r           = r_q;
    assign bus.div_by_zero = dbz_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            dvd   <= '0;
            dvs   <= '0;
            rem   <= '0;
            quo   <= '0;
            q_q   <= '0;
            r_q   <= '0;
            dbz_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        dvd <= bus.a;
                        if (bus.b == '0) begin
                            q_q   <= '1;
                            r_q   <= bus.a;
                            dbz_q <= 1'b1;
                            state <= DONE;
                        end else begin
                            dvs   <= bus.b;
                            rem   <= '0;
                            quo   <= '0;
                            cnt   <= '0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    dvd <= {dvd[WIDTH-2:0], 1'b0};
                    rem <= rem_nxt;
                    quo <= {quo[WIDTH-2:0], ge};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        q_q   <= {quo[WIDTH-2:0], ge};
                        r_q   <= rem_nxt;
                        dbz_q <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pixel_divider.sv
// Randomized bench for pixel_divider: a cycle-level behavioural model built on
// plain / and %, checked every cycle, plus hand-computed directed cases.
module tb_pixel_divider;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    pixel_divider_if #(.WIDTH(W)) dif ();

    pixel_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: an accepted op finishes a fixed number of edges later with a/b, a%b.
    logic         m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
    logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
    int           m_left = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0;
            m_q = '0; m_r = '0; m_left = 0;
        end else if (m_done) begin
            m_done = 1'b0;
            m_busy = 1'b0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1'b1; m_q = p_q; m_r = p_r; m_dbz = 1'b0;
            end
        end else if (dif.start) begin
            m_busy = 1'b1;
            if (dif.b == 0) begin
                m_done = 1'b1; m_q = '1; m_r = dif.a; m_dbz = 1'b1;
            end else begin
                m_left = W;
                p_q = dif.a / dif.b;
                p_r = dif.a % dif.b;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(dif.busy), 32'(m_busy));
        chk("done", 32'(dif.done), 32'(m_done));
        chk("q", 32'(dif.q), 32'(m_q));
        chk("r", 32'(dif.r), 32'(m_r));
        chk("div_by_zero", 32'(dif.div_by_zero), 32'(m_dbz));
    end

    // One request; returns edges from accept to done, busy cycles and results.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          output int lat, output int bcyc,
                          output logic [W-1:0] oq, output logic [W-1:0] orr,
                          output logic od);
        int n = 0;
        while (dif.busy && n < 40) begin @(posedge clk); #2; n++; end
        dif.start = 1'b1; dif.a = av; dif.b = bv;
        @(posedge clk); #2;
        dif.start = 1'b0; dif.a = W'($urandom); dif.b = W'($urandom);
        lat = 0; bcyc = 0;
        while (!dif.done && lat < 40) begin
            if (dif.busy) bcyc++;
            @(posedge clk); #2; lat++;
        end
        if (dif.busy) bcyc++;
        chk("op_timeout", 32'(lat >= 40), 32'd0);
        oq = dif.q; orr = dif.r; od = dif.div_by_zero;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bc, dones, n;
        logic [W-1:0] q, r, av, bv;
        logic d;
        logic [W-1:0] tab_a [4] = '{8'd255, 8'd5, 8'd255, 8'd0};
        logic [W-1:0] tab_b [4] = '{8'd1, 8'd9, 8'd255, 8'd3};
        logic [W-1:0] tab_q [4] = '{8'd255, 8'd0, 8'd1, 8'd0};
        logic [W-1:0] tab_r [4] = '{8'd0, 8'd5, 8'd0, 8'd0};

        dif.start = 1'b0; dif.a = '0; dif.b = '0;
        #3;
        chk("rst_busy", 32'(dif.busy), 32'd0);
        chk("rst_q", 32'(dif.q), 32'd0);
        chk("rst_dbz", 32'(dif.div_by_zero), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #2;

        // 200 / 7
        run_op(8'd200, 8'd7, lat, bc, q, r, d);
        chk("t1_latency", 32'(lat), 32'd8);
        chk("t1_busy_cycles", 32'(bc), 32'd9);
        chk("t1_q", 32'(q), 32'd28);
        chk("t1_r", 32'(r), 32'd4);
        chk("t1_dbz", 32'(d), 32'd0);

        for (int i = 0; i < 4; i++) begin
            run_op(tab_a[i], tab_b[i], lat, bc, q, r, d);
            chk("t2_q", 32'(q), 32'(tab_q[i]));
            chk("t2_r", 32'(r), 32'(tab_r[i]));
        end

        // divide by zero, then a normal op clears the flag
        run_op(8'd77, 8'd0, lat, bc, q, r, d);
        chk("t3_latency", 32'(lat), 32'd0);
        chk("t3_q", 32'(q), 32'hFF);
        chk("t3_r", 32'(r), 32'd77);
        chk("t3_dbz", 32'(d), 32'd1);
        run_op(8'd10, 8'd3, lat, bc, q, r, d);
        chk("t3b_q", 32'(q), 32'd3);
        chk("t3b_r", 32'(r), 32'd1);
        chk("t3b_dbz", 32'(d), 32'd0);

        // start held high, operands change mid-CALC
        n = 0;
        while (dif.busy && n < 40) begin @(posedge clk); #2; n++; end
        dif.start = 1'b1; dif.a = 8'd100; dif.b = 8'd10;
        @(posedge clk); #2;
        repeat (3) begin @(posedge clk); #2; end
        dif.a = 8'd50; dif.b = 8'd5;
        n = 0; dones = 0;
        while (!dif.done && n < 40) begin @(posedge clk); #2; n++; end
        if (dif.done) dones++;
        chk("t4_q", 32'(dif.q), 32'd10);
        chk("t4_r", 32'(dif.r), 32'd0);
        @(posedge clk); #2;
        chk("t4_idle_after_done", 32'(dif.busy), 32'd0);
        @(posedge clk); #2;
        chk("t4_reaccept", 32'(dif.busy), 32'd1);
        chk("t4_single_done", 32'(dones), 32'd1);
        dif.start = 1'b0;
        n = 0;
        while (!dif.done && n < 40) begin @(posedge clk); #2; n++; end
        chk("t4b_q", 32'(dif.q), 32'd10);
        chk("t4b_r", 32'(dif.r), 32'd0);

        // reset during CALC step 4 aborts without a done pulse
        n = 0;
        while (dif.busy && n < 40) begin @(posedge clk); #2; n++; end
        dif.start = 1'b1; dif.a = 8'd200; dif.b = 8'd7;
        @(posedge clk); #2;
        dif.start = 1'b0;
        repeat (3) begin @(posedge clk); #2; end
        rst_n = 1'b0;
        #1;
        chk("t5_busy", 32'(dif.busy), 32'd0);
        chk("t5_q", 32'(dif.q), 32'd0);
        chk("t5_r", 32'(dif.r), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        dones = 0;
        repeat (12) begin @(posedge clk); #2; if (dif.done) dones++; end
        chk("t5_no_done", 32'(dones), 32'd0);
        run_op(8'd9, 8'd2, lat, bc, q, r, d);
        chk("t5_q_after", 32'(q), 32'd4);
        chk("t5_r_after", 32'(r), 32'd1);

        // random sweep, with divisor corners mixed in
        for (int i = 0; i < 2000; i++) begin
            av = W'($urandom);
            case ($urandom_range(0, 15))
                0:       bv = '0;
                1:       bv = 8'd1;
                2:       bv = '1;
                3:       bv = av;
                default: bv = W'($urandom);
            endcase
            run_op(av, bv, lat, bc, q, r, d);
            if (bv != 0) begin
                chk("rnd_q", 32'(q), 32'(av / bv));
                chk("rnd_r", 32'(r), 32'(av % bv));
                chk("rnd_latency", 32'(lat), 32'(W));
            end else begin
                chk("rnd_dbz", 32'(d), 32'd1);
            end
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
